hsid_x_obi_arb: RTL and testbench
=================================

HSID_X_OBI_ARB -- requirements
Module: hsid_x_obi_arb

Interface
REQ-001 Parameter: WORD_WIDTH, default HSID_WORD_WIDTH (32), address/data width.
REQ-002 Parameter: MAX_OUTSTANDING, default 4, max accepted-but-unanswered reads, legal range 1..16.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 a_req_i  in  1  requester A (captured-pixel fetch) read request.
REQ-006 a_addr_i  in  WORD_WIDTH  requester A address.
REQ-007 a_gnt_o  out  1  requester A grant.
REQ-008 a_rvalid_o  out  1  requester A response valid.
REQ-009 a_rdata_o  out  WORD_WIDTH  requester A response data.
REQ-010 b_req_i, b_addr_i, b_gnt_o, b_rvalid_o, b_rdata_o: same widths and meaning for requester B (library fetch).
REQ-011 m_req_o  out  1  shared OBI master read request (we fixed 0, be fixed all-ones, driven by wrapper).
REQ-012 m_addr_o  out  WORD_WIDTH  shared OBI master address.
REQ-013 m_gnt_i  in  1  memory grant.
REQ-014 m_rvalid_i  in  1  memory response valid, in-order.
REQ-015 m_rdata_i  in  WORD_WIDTH  memory response data.
REQ-016 busy_o  out  1  high while outstanding count > 0 or m_req_o high.
REQ-017 err_o  out  1  sticky protocol error flag.

Function
REQ-018 Handshake on a port SHALL be req & gnt in the same cycle; requesters hold req/addr stable until granted.
REQ-019 Outstanding counter cnt (0..MAX_OUTSTANDING) SHALL increment on m_req_o & m_gnt_i, decrement on m_rvalid_i with cnt>0, and stay unchanged when both occur in one cycle.
REQ-020 full = (cnt == MAX_OUTSTANDING), from registered cnt; while full, m_req_o SHALL be 0 and no grant issued, even if m_rvalid_i pops that cycle.
REQ-021 Selection, when not locked: only A requesting -> A; only B -> B; both -> requester not last granted (round-robin pointer rr, 0=A preferred).
REQ-022 m_req_o = selected requester's req & !full; m_addr_o = selected requester's addr; combinational, zero-cycle latency.
REQ-023 If m_req_o is high and m_gnt_i low, lock register SHALL hold current owner until handshake; selection, m_addr_o and owner SHALL not change while locked.
REQ-024 x_gnt_o = m_gnt_i & m_req_o & (owner == x); never both grants high.
REQ-025 On handshake: rr <= other requester, lock cleared, owner ID pushed into in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-026 On m_rvalid_i with cnt>0: head ID popped; x_rvalid_o = 1 for head owner only, same cycle (combinational); x_rdata_o = m_rdata_i for both ports always.
REQ-027 Push and pop in the same cycle SHALL both take effect; a response issued in the same cycle as a grant SHALL route to the older head entry.
REQ-028 m_rvalid_i with cnt==0: no rvalid to either port, response dropped, err_o set and held until rst.
REQ-029 Back-to-back handshakes on consecutive cycles SHALL be supported with no bubble while !full.
REQ-030 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-031 On rst: cnt=0, FIFO empty, rr=0 (A preferred), lock cleared, err_o=0; hence m_req_o, a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, busy_o = 0 while rst is high.
REQ-032 Reset mid-operation SHALL discard all outstanding IDs; subsequent stray m_rvalid_i SHALL set err_o per REQ-028.

Verification
REQ-033 A and B request together, m_gnt_i=1 constant, 4 cycles -> grants A,B,A,B; m_addr_o alternates a_addr_i/b_addr_i each cycle.
REQ-034 A requests addr 0x100, m_gnt_i held 0 for 3 cycles while B raises req -> m_addr_o stays 0x100, owner A; gnt cycle 4 goes to A, B granted next.
REQ-035 MAX_OUTSTANDING=4, A requests 5 reads, no rvalid -> 4 grants, cnt=4, m_req_o=0; one m_rvalid_i -> cnt=3 next cycle, 5th grant issued.
REQ-036 Grants A,B,B then rvalid data 0x11,0x22,0x33 -> a_rvalid_o with 0x11, b_rvalid_o with 0x22, b_rvalid_o with 0x33.
REQ-037 m_rvalid_i with cnt=0 -> no port rvalid, err_o=1 and stays 1; rst pulse -> err_o=0.
REQ-038 Reset asserted with cnt=2 -> next cycle cnt=0, busy_o=0, m_req_o=0, rr favors A.

Source files
------------

// File: rtl/hsid_x_obi_arb_if.sv
// Bus bundle between the two pixel/library fetch requesters, the shared OBI
// read master and the arbiter sitting between them.
interface hsid_x_obi_arb_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  a_req_i;
  logic [WORD_WIDTH-1:0] a_addr_i;
  logic                  a_gnt_o;
  logic                  a_rvalid_o;
  logic [WORD_WIDTH-1:0] a_rdata_o;

  logic                  b_req_i;
  logic [WORD_WIDTH-1:0] b_addr_i;
  logic                  b_gnt_o;
  logic                  b_rvalid_o;
  logic [WORD_WIDTH-1:0] b_rdata_o;

  logic                  m_req_o;
  logic [WORD_WIDTH-1:0] m_addr_o;
  logic                  m_gnt_i;
  logic                  m_rvalid_i;
  logic [WORD_WIDTH-1:0] m_rdata_i;

  logic                  busy_o;
  logic                  err_o;

  // Arbiter side.
  modport slave (
    input  a_req_i, a_addr_i, b_req_i, b_addr_i,
    input  m_gnt_i, m_rvalid_i, m_rdata_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output m_req_o, m_addr_o, busy_o, err_o
  );

  // Environment side: requesters plus memory.
  modport master (
    output a_req_i, a_addr_i, b_req_i, b_addr_i,
    output m_gnt_i, m_rvalid_i, m_rdata_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  m_req_o, m_addr_o, busy_o, err_o
  );
endinterface

// File: rtl/hsid_x_obi_arb.sv
// Two-requester round-robin arbiter onto one OBI read master, with an in-order
// ID FIFO that routes each response back to the requester that issued it.
module hsid_x_obi_arb #(
  parameter int WORD_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  hsid_x_obi_arb_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic [PTR_W-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [MAX_OUTSTANDING-1:0] id_mem_reg, id_mem_next;
  logic                       rr_reg, rr_next;
  logic                       lock_reg, lock_next;
  logic                       owner_reg, owner_next;
  logic                       err_reg, err_next;

  logic                  full;
  logic                  sel_b;
  logic                  sel_req;
  logic [WORD_WIDTH-1:0] sel_addr;
  logic                  m_req;
  logic                  push;
  logic                  pop;
  logic                  head_b;

  assign full = (cnt_reg == CNT_W'(MAX_OUTSTANDING));

  // Owner choice: a pending (locked) request must keep its address stable on
  // the bus, so the lock overrides the round-robin pointer.
  always_comb begin
    sel_b = rr_reg;
    if (lock_reg) begin
      sel_b = owner_reg;
    end else if (bus.a_req_i && !bus.b_req_i) begin
      sel_b = 1'b0;
    end else if (bus.b_req_i && !bus.a_req_i) begin
      sel_b = 1'b1;
    end
  end

  assign sel_req  = sel_b ? bus.b_req_i  : bus.a_req_i;
  assign sel_addr = sel_b ? bus.b_addr_i : bus.a_addr_i;
  assign m_req    = sel_req && !full && !rst;
  assign push     = m_req && bus.m_gnt_i;
  assign pop      = bus.m_rvalid_i && (cnt_reg != '0) && !rst;
  assign head_b   = id_mem_reg[rd_ptr_reg];

  assign bus.m_req_o    = m_req;
  assign bus.m_addr_o   = sel_addr;
  assign bus.a_gnt_o    = push && !sel_b;
  assign bus.b_gnt_o    = push && sel_b;
  assign bus.a_rvalid_o = pop && !head_b;
  assign bus.b_rvalid_o = pop && head_b;
  assign bus.a_rdata_o  = bus.m_rdata_i;
  assign bus.b_rdata_o  = bus.m_rdata_i;
  assign bus.busy_o     = (cnt_reg != '0) || m_req;
  assign bus.err_o      = err_reg;

  // ID storage: each entry only loads when the write pointer lands on it.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id
    assign id_mem_next[gi] = (push && (wr_ptr_reg == PTR_W'(gi))) ? sel_b : id_mem_reg[gi];
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    rr_next     = rr_reg;
    lock_next   = m_req && !bus.m_gnt_i;
    owner_next  = sel_b;
    err_next    = err_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      rr_next     = !sel_b;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
    // A response with nothing outstanding has no owner; drop it and flag.
    if (bus.m_rvalid_i && (cnt_reg == '0)) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      id_mem_reg <= '0;
      rr_reg     <= 1'b0;
      lock_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      id_mem_reg <= id_mem_next;
      rr_reg     <= rr_next;
      lock_reg   <= lock_next;
      owner_reg  <= owner_next;
      err_reg    <= err_next;
    end
  end
endmodule

// File: tb/tb_hsid_x_obi_arb.sv
// Directed bench for hsid_x_obi_arb: a cycle table for arbitration and response
// routing, plus hand-written lock, full, reset and stray-response sequences.
module tb_hsid_x_obi_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hsid_x_obi_arb_if #(.WORD_WIDTH(32)) bus ();

  hsid_x_obi_arb #(.WORD_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        a_req;
    logic        b_req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_agnt;
    logic        e_bgnt;
    logic        e_arv;
    logic        e_brv;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  localparam logic [31:0] AA = 32'h0000_00A0;
  localparam logic [31:0] BA = 32'h0000_00B0;

  vec_t tbl [14];

  function automatic vec_t mk(input logic ar, input logic br, input logic g, input logic rv,
                              input logic [31:0] rd, input logic mreq, input logic [31:0] maddr,
                              input logic ag, input logic bg, input logic arv, input logic brv,
                              input logic busy, input logic err);
    vec_t v;
    v.a_req = ar;  v.b_req = br;  v.gnt = g;   v.rv = rv;   v.rdata = rd;
    v.e_mreq = mreq; v.e_maddr = maddr; v.e_agnt = ag; v.e_bgnt = bg;
    v.e_arv = arv; v.e_brv = brv; v.e_busy = busy; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic [31:0] aa, input logic br, input logic [31:0] ba,
                       input logic g, input logic rv, input logic [31:0] rd);
    bus.a_req_i    = ar;
    bus.a_addr_i   = aa;
    bus.b_req_i    = br;
    bus.b_addr_i   = ba;
    bus.m_gnt_i    = g;
    bus.m_rvalid_i = rv;
    bus.m_rdata_i  = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Both request with constant grant: A,B,A,B, then full while responses drain.
    tbl[0]  = mk(1, 1, 1, 0, 32'h0,  1, AA, 1, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 1, 1, 0, 32'h0,  1, BA, 0, 1, 0, 0, 1, 0);
    tbl[2]  = mk(1, 1, 1, 0, 32'h0,  1, AA, 1, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 1, 0, 32'h0,  1, BA, 0, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1, 1, 1, 1, 32'h11, 0, AA, 0, 0, 1, 0, 1, 0);
    tbl[5]  = mk(1, 1, 1, 0, 32'h0,  1, AA, 1, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 32'h22, 0, 0,  0, 0, 0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 32'h33, 0, 0,  0, 0, 1, 0, 1, 0);
    tbl[8]  = mk(1, 0, 1, 1, 32'h44, 1, AA, 1, 0, 0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 1, 32'h55, 0, 0,  0, 0, 1, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 1, 32'h66, 0, 0,  0, 0, 1, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 32'h77, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 1);

    // Reset: requests and a response present while rst is high must be ignored.
    drive(1, AA, 1, BA, 1, 1, 32'h99);
    tick();
    tick();
    chk("rst_mreq", 32'(bus.m_req_o), 32'd0);
    chk("rst_agnt", 32'(bus.a_gnt_o), 32'd0);
    chk("rst_bgnt", 32'(bus.b_gnt_o), 32'd0);
    chk("rst_arv",  32'(bus.a_rvalid_o), 32'd0);
    chk("rst_brv",  32'(bus.b_rvalid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_err",  32'(bus.err_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].a_req, AA, tbl[i].b_req, BA, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      #1;
      chk($sformatf("v%0d_mreq", i), 32'(bus.m_req_o), 32'(tbl[i].e_mreq));
      if (tbl[i].a_req || tbl[i].b_req)
        chk($sformatf("v%0d_maddr", i), bus.m_addr_o, tbl[i].e_maddr);
      chk($sformatf("v%0d_agnt", i), 32'(bus.a_gnt_o), 32'(tbl[i].e_agnt));
      chk($sformatf("v%0d_bgnt", i), 32'(bus.b_gnt_o), 32'(tbl[i].e_bgnt));
      chk($sformatf("v%0d_arv", i), 32'(bus.a_rvalid_o), 32'(tbl[i].e_arv));
      chk($sformatf("v%0d_brv", i), 32'(bus.b_rvalid_o), 32'(tbl[i].e_brv));
      if (tbl[i].e_arv) chk($sformatf("v%0d_ardata", i), bus.a_rdata_o, tbl[i].rdata);
      if (tbl[i].e_brv) chk($sformatf("v%0d_brdata", i), bus.b_rdata_o, tbl[i].rdata);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_err", i), 32'(bus.err_o), 32'(tbl[i].e_err));
      $display("vec %0d: a_req=%b b_req=%b gnt=%b rv=%b -> m_req=%b addr=%h ag=%b bg=%b arv=%b brv=%b busy=%b err=%b",
               i, tbl[i].a_req, tbl[i].b_req, tbl[i].gnt, tbl[i].rv, bus.m_req_o, bus.m_addr_o,
               bus.a_gnt_o, bus.b_gnt_o, bus.a_rvalid_o, bus.b_rvalid_o, bus.busy_o, bus.err_o);
      tick();
    end

    // Sticky error survives idle cycles, cleared only by reset.
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("err_sticky", 32'(bus.err_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_clear", 32'(bus.err_o), 32'd0);
    $display("seq err: sticky then cleared by reset, err=%b", bus.err_o);

    // Lock: move rr to B first, so only the lock keeps A as owner.
    drive(1, 32'h100, 0, 32'h200, 1, 0, 0);
    #1 chk("lk_pre_agnt", 32'(bus.a_gnt_o), 32'd1);
    tick();
    drive(0, 32'h100, 0, 32'h200, 0, 1, 32'hAB);
    #1 chk("lk_pre_arv", 32'(bus.a_rvalid_o), 32'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 32'h100, (c > 0), 32'h200, 0, 0, 0);
      #1;
      chk($sformatf("lk%0d_mreq", c), 32'(bus.m_req_o), 32'd1);
      chk($sformatf("lk%0d_maddr", c), bus.m_addr_o, 32'h100);
      chk($sformatf("lk%0d_gnt", c), 32'({bus.a_gnt_o, bus.b_gnt_o}), 32'd0);
      tick();
    end
    drive(1, 32'h100, 1, 32'h200, 1, 0, 0);
    #1;
    chk("lk3_maddr", bus.m_addr_o, 32'h100);
    chk("lk3_gnt", 32'({bus.a_gnt_o, bus.b_gnt_o}), 32'b10);
    tick();
    drive(0, 32'h100, 1, 32'h200, 1, 0, 0);
    #1;
    chk("lk4_maddr", bus.m_addr_o, 32'h200);
    chk("lk4_gnt", 32'({bus.a_gnt_o, bus.b_gnt_o}), 32'b01);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h5A);
    #1 chk("lk_rsp0", 32'({bus.a_rvalid_o, bus.b_rvalid_o}), 32'b10);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h5B);
    #1 chk("lk_rsp1", 32'({bus.a_rvalid_o, bus.b_rvalid_o}), 32'b01);
    tick();
    $display("seq lock: A held through 3 stalled cycles, then A and B granted in order");

    // Full: five reads from A, only four accepted until a response pops.
    for (int c = 0; c < 4; c++) begin
      drive(1, 32'h300, 0, 0, 1, 0, 0);
      #1 chk($sformatf("fl%0d_agnt", c), 32'(bus.a_gnt_o), 32'd1);
      tick();
    end
    drive(1, 32'h300, 0, 0, 1, 0, 0);
    #1;
    chk("fl_full_mreq", 32'(bus.m_req_o), 32'd0);
    chk("fl_full_agnt", 32'(bus.a_gnt_o), 32'd0);
    chk("fl_full_busy", 32'(bus.busy_o), 32'd1);
    tick();
    drive(1, 32'h300, 0, 0, 1, 1, 32'hC0);
    #1;
    chk("fl_pop_mreq", 32'(bus.m_req_o), 32'd0);
    chk("fl_pop_arv", 32'(bus.a_rvalid_o), 32'd1);
    tick();
    drive(1, 32'h300, 0, 0, 1, 0, 0);
    #1 chk("fl_5th_agnt", 32'(bus.a_gnt_o), 32'd1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 1, 32'hD0 + 32'(c));
      #1 chk($sformatf("fl_drain%0d", c), 32'(bus.a_rvalid_o), 32'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_idle_busy", 32'(bus.busy_o), 32'd0);
    chk("fl_idle_err", 32'(bus.err_o), 32'd0);
    $display("seq full: 4 accepted, stalled while full, 5th after one response");

    // Reset with two reads outstanding discards them.
    for (int c = 0; c < 2; c++) begin
      drive(1, 32'h400, 0, 0, 1, 0, 0);
      tick();
    end
    rst = 1'b1;
    drive(1, 32'h400, 1, 32'h500, 0, 0, 0);
    tick();
    chk("mr_busy", 32'(bus.busy_o), 32'd0);
    chk("mr_mreq", 32'(bus.m_req_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_rr_addr", bus.m_addr_o, 32'h400);
    chk("mr_rr_mreq", 32'(bus.m_req_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hEE);
    #1 chk("mr_stray_rv", 32'({bus.a_rvalid_o, bus.b_rvalid_o}), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("mr_stray_err", 32'(bus.err_o), 32'd1);
    $display("seq reset: outstanding discarded, A preferred, stray response flagged");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
